// File: rtl/ece_mem_arbiter_if.sv
// Bus bundle between the requesters (host loader, encoder read/write
// streams) and the SRAM macro, as seen through the arbiter.
interface ece_mem_arbiter_if #(
    parameter int AW = 15,
    parameter int DW = 15
);
    // Host loader port
    logic          h_req;
    logic          h_we;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata;
    logic          h_gnt;
    logic          h_rvalid;

    // Encoder read stream (read-only)
    logic          r_req;
    logic [AW-1:0] r_addr;
    logic          r_gnt;
    logic          r_rvalid;

    // Encoder write stream (write-only)
    logic          w_req;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    logic          w_gnt;

    // Shared read return
    logic [DW-1:0] rdata;

    // SRAM macro side
    logic          mem_cen;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Arbiter view
    modport slave (
        input  h_req, h_we, h_addr, h_wdata,
        input  r_req, r_addr,
        input  w_req, w_addr, w_wdata,
        input  mem_rdata,
        output h_gnt, h_rvalid,
        output r_gnt, r_rvalid,
        output w_gnt,
        output rdata,
        output mem_cen, mem_wen, mem_addr, mem_wdata
    );

    // Requester / memory-model view
    modport master (
        output h_req, h_we, h_addr, h_wdata,
        output r_req, r_addr,
        output w_req, w_addr, w_wdata,
        output mem_rdata,
        input  h_gnt, h_rvalid,
        input  r_gnt, r_rvalid,
        input  w_gnt,
        input  rdata,
        input  mem_cen, mem_wen, mem_addr, mem_wdata
    );
endinterface

// File: rtl/ece_mem_arbiter.sv
// Single-port image SRAM arbiter for host loader (H), encoder read (R)
// and encoder write (W). H has priority up to a burst cap whenever R or W
// is waiting; R and W alternate round-robin. One access per cycle, fixed
// one-cycle read latency, nothing queued internally.
module ece_mem_arbiter #(
    parameter int AW             = 15,
    parameter int DW             = 15,
    parameter int HOST_MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    ece_mem_arbiter_if.slave    bus
);

    localparam int            HW   = $clog2(HOST_MAX_BURST + 1);
    localparam logic [HW-1:0] HMAX = HW'(HOST_MAX_BURST);

    // Last R/W winner; the other one wins the next R/W tie.
    typedef enum logic {
        RW_R = 1'b0,
        RW_W = 1'b1
    } rw_e;

    logic [HW-1:0] r_hcnt;
    rw_e           r_last_rw;
    logic          r_h_rvalid;
    logic          r_r_rvalid;

    logic [HW-1:0] w_hcnt_nxt;
    rw_e           w_last_rw_nxt;
    logic          w_rw_pend;
    logic          w_h_win;
    logic          w_r_win;
    logic          w_w_win;
    logic          w_mux_wen;
    logic [AW-1:0] w_mux_addr;
    logic [DW-1:0] w_mux_wdata;

    // Grant decision: host first unless capped with R/W waiting, then round-robin R/W
    always_comb begin
        w_h_win   = 1'b0;
        w_r_win   = 1'b0;
        w_w_win   = 1'b0;
        w_rw_pend = bus.r_req | bus.w_req;
        if (!rst) begin
            if (bus.h_req && ((r_hcnt < HMAX) || !w_rw_pend)) begin
                w_h_win = 1'b1;
            end else if (bus.r_req && bus.w_req) begin
                if (r_last_rw == RW_W) begin
                    w_r_win = 1'b1;
                end else begin
                    w_w_win = 1'b1;
                end
            end else if (bus.r_req) begin
                w_r_win = 1'b1;
            end else if (bus.w_req) begin
                w_w_win = 1'b1;
            end
        end
    end

    // Next burst count and round-robin pointer
    always_comb begin
        w_hcnt_nxt    = '0;
        w_last_rw_nxt = r_last_rw;
        if (w_h_win) begin
            w_hcnt_nxt = (r_hcnt == HMAX) ? HMAX : r_hcnt + HW'(1);
        end
        if (w_r_win) begin
            w_last_rw_nxt = RW_R;
        end
        if (w_w_win) begin
            w_last_rw_nxt = RW_W;
        end
    end

    // State registers: burst count, RR pointer and one-cycle read-valid flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcnt     <= '0;
            r_last_rw  <= RW_W;
            r_h_rvalid <= 1'b0;
            r_r_rvalid <= 1'b0;
        end else begin
            r_hcnt     <= w_hcnt_nxt;
            r_last_rw  <= w_last_rw_nxt;
            r_h_rvalid <= w_h_win & ~bus.h_we;
            r_r_rvalid <= w_r_win;
        end
    end

    // Memory command mux from the granted requester
    always_comb begin
        w_mux_wen   = 1'b0;
        w_mux_addr  = '0;
        w_mux_wdata = '0;
        if (w_h_win) begin
            w_mux_wen   = bus.h_we;
            w_mux_addr  = bus.h_addr;
            w_mux_wdata = bus.h_wdata;
        end else if (w_r_win) begin
            w_mux_addr  = bus.r_addr;
        end else if (w_w_win) begin
            w_mux_wen   = 1'b1;
            w_mux_addr  = bus.w_addr;
            w_mux_wdata = bus.w_wdata;
        end
    end

    // Drive grants, SRAM command and read-return qualifiers
    always_comb begin
        bus.h_gnt     = w_h_win;
        bus.r_gnt     = w_r_win;
        bus.w_gnt     = w_w_win;
        bus.mem_cen   = w_h_win | w_r_win | w_w_win;
        bus.mem_wen   = w_mux_wen;
        bus.mem_addr  = w_mux_addr;
        bus.mem_wdata = w_mux_wdata;
        bus.h_rvalid  = r_h_rvalid;
        bus.r_rvalid  = r_r_rvalid;
        bus.rdata     = bus.mem_rdata;
    end

endmodule

// File: tb/tb_ece_mem_arbiter.sv
// Bench for ece_mem_arbiter: directed scenarios with literal expectations,
// a spec-level reference model compared every cycle, and a random phase.
module tb_ece_mem_arbiter;

    localparam int AW  = 15;
    localparam int DW  = 15;
    localparam int HMB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ece_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    ece_mem_arbiter #(
        .AW(AW),
        .DW(DW),
        .HOST_MAX_BURST(HMB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // SRAM macro: one-cycle synchronous read
    logic [DW-1:0] sram [0:(1<<AW)-1];
    logic [DW-1:0] sram_q = '0;
    always @(posedge clk) begin
        if (bus.mem_cen) begin
            if (bus.mem_wen) sram[bus.mem_addr] <= bus.mem_wdata;
            else             sram_q <= sram[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = sram_q;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: host run length, whose turn among R/W, pending read returns
    int      m_hrun   = 0;
    bit      m_w_next = 1'b0;   // 0: R wins next R/W tie
    bit      m_hrv    = 1'b0;
    bit      m_rrv    = 1'b0;
    bit      m_known  = 1'b0;
    int      m_rd     = 0;
    int      mmem [int];

    always @(negedge clk) begin
        bit hg, rg, wg, rdr;
        int a;
        hg = 0; rg = 0; wg = 0; rdr = 0; a = 0;
        chk("h_rvalid", 32'(bus.h_rvalid), 32'(m_hrv));
        chk("r_rvalid", 32'(bus.r_rvalid), 32'(m_rrv));
        if ((m_hrv || m_rrv) && m_known) chk("rdata", 32'(bus.rdata), 32'(m_rd));
        if (!rst) begin
            if (bus.h_req && (m_hrun < HMB || !(bus.r_req || bus.w_req))) hg = 1;
            else if (bus.r_req && bus.w_req) begin
                if (m_w_next) wg = 1; else rg = 1;
            end
            else if (bus.r_req) rg = 1;
            else if (bus.w_req) wg = 1;
        end
        chk("h_gnt", 32'(bus.h_gnt), 32'(hg));
        chk("r_gnt", 32'(bus.r_gnt), 32'(rg));
        chk("w_gnt", 32'(bus.w_gnt), 32'(wg));
        chk("gnt_onehot", 32'($countones({bus.h_gnt, bus.r_gnt, bus.w_gnt}) <= 1), 32'd1);
        chk("mem_cen", 32'(bus.mem_cen), 32'(hg | rg | wg));
        if (hg | rg | wg) begin
            if (hg) a = int'(bus.h_addr);
            if (rg) a = int'(bus.r_addr);
            if (wg) a = int'(bus.w_addr);
            chk("mem_wen", 32'(bus.mem_wen), 32'(wg | (hg & bus.h_we)));
            chk("mem_addr", 32'(bus.mem_addr), 32'(a));
            if (wg) chk("mem_wdata", 32'(bus.mem_wdata), 32'(bus.w_wdata));
            if (hg && bus.h_we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(bus.h_wdata));
        end
        if (rst) begin
            m_hrun = 0; m_w_next = 0; m_hrv = 0; m_rrv = 0;
        end else begin
            m_hrun = hg ? ((m_hrun + 1 > HMB) ? HMB : m_hrun + 1) : 0;
            if (rg) m_w_next = 1;
            if (wg) m_w_next = 0;
            m_hrv = hg && !bus.h_we;
            m_rrv = rg;
            rdr   = m_hrv || m_rrv;
            if (wg) mmem[a] = int'(bus.w_wdata);
            if (hg && bus.h_we) mmem[a] = int'(bus.h_wdata);
            if (rdr) begin
                m_known = mmem.exists(a);
                m_rd    = m_known ? mmem[a] : 0;
            end
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs;
        bus.h_req = 0; bus.h_we = 0; bus.h_addr = '0; bus.h_wdata = '0;
        bus.r_req = 0; bus.r_addr = '0;
        bus.w_req = 0; bus.w_addr = '0; bus.w_wdata = '0;
    endtask

    task automatic reset2;
        cyc;
        rst = 1;
        clear_reqs;
        cyc;
        cyc;
        rst = 0;
    endtask

    string pat;

    initial begin
        clear_reqs;
        // T1: reset with every requester asking
        bus.h_req = 1; bus.r_req = 1; bus.w_req = 1;
        for (int i = 0; i < 2; i++) begin
            cyc;
            #1;
            chk("t1_h_gnt", 32'(bus.h_gnt), 0);
            chk("t1_r_gnt", 32'(bus.r_gnt), 0);
            chk("t1_w_gnt", 32'(bus.w_gnt), 0);
            chk("t1_mem_cen", 32'(bus.mem_cen), 0);
        end
        cyc;
        rst = 0; bus.h_req = 0;
        #1;
        chk("t1_first_r", 32'(bus.r_gnt), 1);
        chk("t1_first_w", 32'(bus.w_gnt), 0);

        // T2: R/W alternate, R first
        reset2;
        for (int i = 1; i <= 6; i++) begin
            if (i > 1) cyc;
            bus.r_req = 1; bus.w_req = 1;
            bus.r_addr = 15'(i); bus.w_addr = 15'(i + 100); bus.w_wdata = 15'(i * 3);
            #1;
            chk("t2_r_gnt", 32'(bus.r_gnt), 32'(i % 2));
            chk("t2_w_gnt", 32'(bus.w_gnt), 32'((i + 1) % 2));
            chk("t2_mem_wen", 32'(bus.mem_wen), 32'((i + 1) % 2));
            chk("t2_r_rvalid", 32'(bus.r_rvalid), 32'((i + 1) % 2));
        end

        // T3: host capped at 4 while R waits
        reset2;
        pat = "HHHHRHH";
        for (int i = 0; i < 7; i++) begin
            if (i > 0) cyc;
            bus.h_req = 1; bus.h_addr = 15'd1; bus.r_req = 1; bus.r_addr = 15'd2;
            #1;
            chk("t3_h_gnt", 32'(bus.h_gnt), 32'(pat[i] == "H"));
            chk("t3_r_gnt", 32'(bus.r_gnt), 32'(pat[i] == "R"));
        end

        // T4: host alone, then R arrives with the burst count saturated
        reset2;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) cyc;
            bus.h_req = 1; bus.h_addr = 15'(i);
            #1;
            chk("t4_h_gnt", 32'(bus.h_gnt), 1);
        end
        cyc;
        bus.r_req = 1;
        #1;
        chk("t4_r_gnt", 32'(bus.r_gnt), 1);
        chk("t4_h_wait", 32'(bus.h_gnt), 0);

        // T5: host write then encoder read of the same word
        reset2;
        bus.h_req = 1; bus.h_we = 1; bus.h_addr = 15'h0005; bus.h_wdata = 15'h1234;
        #1;
        chk("t5_h_gnt", 32'(bus.h_gnt), 1);
        chk("t5_wr_wen", 32'(bus.mem_wen), 1);
        chk("t5_wr_addr", 32'(bus.mem_addr), 32'h5);
        chk("t5_wr_data", 32'(bus.mem_wdata), 32'h1234);
        cyc;
        bus.h_req = 0; bus.h_we = 0; bus.r_req = 1; bus.r_addr = 15'h0005;
        #1;
        chk("t5_r_gnt", 32'(bus.r_gnt), 1);
        chk("t5_rd_wen", 32'(bus.mem_wen), 0);
        chk("t5_rd_rvalid_early", 32'(bus.r_rvalid), 0);
        cyc;
        bus.r_req = 0;
        #1;
        chk("t5_r_rvalid", 32'(bus.r_rvalid), 1);
        chk("t5_rdata", 32'(bus.rdata), 32'h1234);
        chk("t5_idle_cen", 32'(bus.mem_cen), 0);

        // T6: reset lands in the read-grant cycle
        reset2;
        bus.r_req = 1; bus.r_addr = 15'h0005;
        #1;
        chk("t6_r_gnt", 32'(bus.r_gnt), 1);
        #1;
        rst = 1;
        #1;
        chk("t6_gnt_forced", 32'(bus.r_gnt), 0);
        cyc;
        #1;
        chk("t6_r_rvalid", 32'(bus.r_rvalid), 0);
        cyc;
        rst = 0; bus.w_req = 1;
        #1;
        chk("t6_rr_restart", 32'(bus.r_gnt), 1);

        // Random traffic, model compares every cycle
        reset2;
        for (int i = 0; i < 600; i++) begin
            cyc;
            rst          = ($urandom_range(0, 59) == 0);
            bus.h_req    = 1'($urandom_range(0, 1));
            bus.h_we     = 1'($urandom_range(0, 1));
            bus.h_addr   = 15'($urandom_range(0, 15));
            bus.h_wdata  = 15'($urandom);
            bus.r_req    = 1'($urandom_range(0, 1));
            bus.r_addr   = 15'($urandom_range(0, 15));
            bus.w_req    = 1'($urandom_range(0, 1));
            bus.w_addr   = 15'($urandom_range(0, 15));
            bus.w_wdata  = 15'($urandom);
        end
        cyc;
        rst = 0;
        clear_reqs;
        cyc;
        cyc;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
